// File: rtl/load_store_unit_if.sv
// Bundle of the execute-stage request, data-bus, writeback and exception
// signals around the load/store unit. The unit uses the slave modport; the
// environment (execute stage plus bus controller) uses the master modport.
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready.
// A bus transfer completes on a rising edge where a strobe (bus_rd or bus_wd)
// is high and bus_ready && !bus_busy; until then the strobe, bus_addr and
// bus_wdata are held stable by the unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        bus_rd;
    logic        bus_wd;
    logic [31:0] bus_addr;
    logic [1:0]  bus_size;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_busy;

    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done;
    logic        exc_misaligned;
    logic        exc_illegal;
    logic [31:0] exc_addr;

    modport slave (
        input  req_valid, req_store, req_funct3, req_base, req_offset,
               req_wdata, req_rd, bus_rdata, bus_ready, bus_busy,
        output req_ready, bus_rd, bus_wd, bus_addr, bus_size, bus_wdata,
               wb_we, wb_rd, wb_data, done, exc_misaligned, exc_illegal,
               exc_addr
    );

    modport master (
        output req_valid, req_store, req_funct3, req_base, req_offset,
               req_wdata, req_rd, bus_rdata, bus_ready, bus_busy,
        input  req_ready, bus_rd, bus_wd, bus_addr, bus_size, bus_wdata,
               wb_we, wb_rd, wb_data, done, exc_misaligned, exc_illegal,
               exc_addr
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit. One request at a time; every bus access is a
// word-aligned 32-bit transfer. Sub-word stores are done as read-modify-write,
// sub-word loads are extracted from the read word and sign/zero extended.
module load_store_unit (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave lsu,
    output logic [2:0]       o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STORE  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_DONE   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_eff;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic        r_illegal;
    logic [31:0] r_cap;
    logic [31:0] r_merged;
    logic [31:0] r_exc_addr;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_rd;

    logic        w_accept;
    logic        w_grant;
    logic [31:0] w_eff;
    logic        w_illegal;
    logic        w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic [31:0] w_merged;

    assign w_accept = lsu.req_valid && (r_state == S_IDLE);
    assign w_grant  = lsu.bus_ready && !lsu.bus_busy;
    assign w_eff    = lsu.req_base + lsu.req_offset;

    // Lanes of the read word addressed by the latched effective address.
    assign w_byte = lsu.bus_rdata[{r_eff[1:0], 3'b000} +: 8];
    assign w_half = lsu.bus_rdata[{r_eff[1], 4'b0000} +: 16];

    assign lsu.bus_addr = {r_eff[31:2], 2'b00};
    assign lsu.bus_size = 2'b10;
    assign lsu.exc_addr = r_exc_addr;
    assign o_dbg_state  = r_state;

    // In the DONE cycle of a load show the fresh result; otherwise hold the last one.
    assign lsu.wb_rd   = (r_state == S_DONE && !r_store) ? r_rd  : r_wb_rd;
    assign lsu.wb_data = (r_state == S_DONE && !r_store) ? r_cap : r_wb_data;

    // Classify the incoming request: illegal funct3 and alignment.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        if (lsu.req_store) begin
            w_illegal = (lsu.req_funct3 >= 3'd3);
        end else begin
            w_illegal = (lsu.req_funct3 == 3'd3) || (lsu.req_funct3[2:1] == 2'b11);
        end
        if (lsu.req_funct3[1:0] == 2'b01) begin
            w_misaligned = w_eff[0];
        end else if (lsu.req_funct3[1:0] == 2'b10) begin
            w_misaligned = (w_eff[1:0] != 2'b00);
        end
    end

    // Extend the loaded lane and build the merged word for sub-word stores.
    always_comb begin
        case (r_funct3)
            3'd0:    w_ext = {{24{w_byte[7]}}, w_byte};
            3'd4:    w_ext = {24'd0, w_byte};
            3'd1:    w_ext = {{16{w_half[15]}}, w_half};
            3'd5:    w_ext = {16'd0, w_half};
            default: w_ext = lsu.bus_rdata;
        endcase
        w_merged = lsu.bus_rdata;
        if (r_funct3[1:0] == 2'b00) begin
            w_merged[{r_eff[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else if (r_funct3[1:0] == 2'b01) begin
            w_merged[{r_eff[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    // Next state and the state-decoded strobes/pulses.
    always_comb begin
        w_next             = r_state;
        lsu.req_ready      = 1'b0;
        lsu.bus_rd         = 1'b0;
        lsu.bus_wd         = 1'b0;
        lsu.bus_wdata      = 32'd0;
        lsu.done           = 1'b0;
        lsu.wb_we          = 1'b0;
        lsu.exc_misaligned = 1'b0;
        lsu.exc_illegal    = 1'b0;
        case (r_state)
            S_IDLE: begin
                lsu.req_ready = 1'b1;
                if (lsu.req_valid) begin
                    if (w_illegal || w_misaligned)      w_next = S_FAULT;
                    else if (!lsu.req_store)            w_next = S_LOAD;
                    else if (lsu.req_funct3[1:0] == 2'b10) w_next = S_STORE;
                    else                                w_next = S_RMW_RD;
                end
            end
            S_LOAD: begin
                lsu.bus_rd = 1'b1;
                if (w_grant) w_next = S_DONE;
            end
            S_STORE: begin
                lsu.bus_wd    = 1'b1;
                lsu.bus_wdata = r_wdata;
                if (w_grant) w_next = S_DONE;
            end
            S_RMW_RD: begin
                lsu.bus_rd = 1'b1;
                if (w_grant) w_next = S_RMW_WR;
            end
            S_RMW_WR: begin
                lsu.bus_wd    = 1'b1;
                lsu.bus_wdata = r_merged;
                if (w_grant) w_next = S_DONE;
            end
            S_DONE: begin
                lsu.done  = 1'b1;
                lsu.wb_we = !r_store && (r_rd != 5'd0);
                w_next    = S_IDLE;
            end
            S_FAULT: begin
                lsu.done           = 1'b1;
                lsu.exc_illegal    = r_illegal;
                lsu.exc_misaligned = !r_illegal;
                w_next             = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register, request latch, captured read data and held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_store    <= 1'b0;
            r_funct3   <= 3'd0;
            r_eff      <= 32'd0;
            r_wdata    <= 32'd0;
            r_rd       <= 5'd0;
            r_illegal  <= 1'b0;
            r_cap      <= 32'd0;
            r_merged   <= 32'd0;
            r_exc_addr <= 32'd0;
            r_wb_data  <= 32'd0;
            r_wb_rd    <= 5'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_store   <= lsu.req_store;
                r_funct3  <= lsu.req_funct3;
                r_eff     <= w_eff;
                r_wdata   <= lsu.req_wdata;
                r_rd      <= lsu.req_rd;
                r_illegal <= w_illegal;
                if (w_illegal || w_misaligned) r_exc_addr <= w_eff;
            end
            if (r_state == S_LOAD && w_grant)   r_cap    <= w_ext;
            if (r_state == S_RMW_RD && w_grant) r_merged <= w_merged;
            if (r_state == S_DONE && !r_store) begin
                r_wb_data <= r_cap;
                r_wb_rd   <= r_rd;
            end
        end
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the core's execute stage and the data bus controller. It accepts one RV32I load or store at a time and computes the effective address. It checks alignment and funct3 legality. Every access goes to the bus as a word-aligned 32-bit transfer: sub-word stores become a read-modify-write, and loaded bytes/halves are extracted and sign- or zero-extended for writeback.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present from execute stage.
- `req_ready` out 1: unit idle; a request is accepted on an edge where `req_valid && req_ready`.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- `req_base` in 32: rs1 value.
- `req_offset` in 32: sign-extended immediate.
- `req_wdata` in 32: rs2 value.
- `req_rd` in 5: destination register of a load.
- `bus_rd` out 1: read strobe.
- `bus_wd` out 1: write strobe.
- `bus_addr` out 32: byte address, always `{eff[31:2],2'b00}`; drives both controller address inputs.
- `bus_size` out 2: always 2'b10; drives both controller size inputs.
- `bus_wdata` out 32: write data.
- `bus_rdata` in 32: read data; combinational, valid while `bus_rd` is high and a grant is present.
- `bus_ready` in 1: controller ready.
- `bus_busy` in 1: controller busy. A grant is `bus_ready && !bus_busy`.
- `wb_we` out 1: one-cycle pulse to write back a load result (suppressed when rd = 0).
- `wb_rd` out 5: writeback register index.
- `wb_data` out 32: extended load result.
- `done` out 1: one-cycle pulse when any op (load, store, or fault) retires.
- `exc_misaligned` out 1: one-cycle pulse on an alignment fault.
- `exc_illegal` out 1: one-cycle pulse on an illegal funct3.
- `exc_addr` out 32: faulting effective address, held until the next fault.

## Operation
- On accept, latch all request fields and compute `eff = req_base + req_offset` (mod 2^32, carry dropped).
- Legality check:
  - Load funct3 in {3,6,7} is illegal.
  - Store funct3 ≥ 3 is illegal.
- Alignment check:
  - Halfword (funct3[1:0] = 01) requires eff[0] = 0.
  - Word requires eff[1:0] = 0.
- Illegal funct3 takes priority over misalignment. Either fault goes to FAULT with no bus access.
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, DONE, FAULT.
  - IDLE: `req_ready` = 1. On accept, go to FAULT, LOAD (loads), STORE (SW), or RMW_RD (SB/SH).
  - LOAD: `bus_rd` = 1. On grant, capture the extended lane and go to DONE; otherwise hold.
  - STORE: `bus_wd` = 1 with `bus_wdata` = rs2. On grant, go to DONE.
  - RMW_RD: `bus_rd` = 1. On grant, capture the merged word and go to RMW_WR.
  - RMW_WR: `bus_wd` = 1 with the merged word. On grant, go to DONE.
  - DONE: `done` = 1. `wb_we` = 1 if the op is a load and rd ≠ 0. Go to IDLE.
  - FAULT: `done` = 1, plus the matching `exc_*` = 1. Load `exc_addr` = eff. Go to IDLE.
- Lane extraction for loads:
  - Byte k = eff[1:0] selects bits [8k+7:8k]. LB sign-extends bit 7; LBU zero-extends.
  - Half h = eff[1] selects bits [16h+15:16h]. LH sign-extends bit 15; LHU zero-extends.
- Merge for stores: the read word with the selected byte/half lane replaced by rs2[7:0] or rs2[15:0].
- `bus_rd` and `bus_wd` are never high together. Strobes stay asserted and `bus_addr`/`bus_wdata` stay stable until the grant.

## Timing
- Reset values: state IDLE; `req_ready` = 1; all strobes, `done`, `wb_we`, `exc_*` = 0; `wb_rd`, `wb_data`, `exc_addr`, `bus_addr`, `bus_wdata` = 0; `bus_size` = 2'b10.
- `rst` at any edge, including mid-LOAD or mid-RMW: return to IDLE. No `done`, writeback, or exception pulse. Strobes drop in the following cycle. A RMW interrupted before RMW_WR leaves memory unchanged.
- Latency with an immediate grant, counted from the accept edge to the `done` cycle:
  - LW/LB/LH and SW: strobe cycle, then DONE cycle = 2 cycles.
  - SB/SH: 3 cycles.
  - Faults: 1 cycle.
- Each cycle without a grant adds one cycle. There is no timeout.
- `req_ready` is low from the cycle after accept until IDLE is re-entered, so back-to-back requests are at least 3 cycles apart for word ops.
- `wb_data`/`wb_rd` hold their values after the `wb_we` pulse until the next load retires.

## Test plan
- LW: base 0x100, offset 4, memory[0x104] = 0xDEADBEEF -> `bus_rd` at 0x104 for one cycle; `wb_we` with `wb_data` = 0xDEADBEEF two cycles after accept.
- LB/LBU at eff 0x107, word 0x80112233 -> LB gives 0xFFFFFF80, LBU gives 0x00000080; LH at 0x106 gives 0xFFFF8011.
- SB: rs2 0xAB at eff 0x101, word 0x11223344 -> read, then `bus_wd` with 0x1122AB44 at 0x100; `done` three cycles after accept.
- SH at eff 0x103 -> `exc_misaligned` and `done` one cycle after accept, `exc_addr` = 0x103, no strobe. Load with funct3 = 3 -> `exc_illegal`.
- LW with `bus_busy` high for 3 cycles -> `bus_rd` and `bus_addr` held stable for 4 cycles; data captured only at the grant.
- `rst` asserted in RMW_WR's first cycle while busy -> IDLE next cycle; no `wd` grant, no `done`, memory word unchanged.
